// File: rtl/pipe_pkg.sv
// pipe_pkg -- constants shared by the ID/EX pipeline register and its hazard logic.
//   ALUOp classes from the main decoder, R-type funct codes, bit positions
//   inside the 4-bit control bundle {RegWrite, MemRead, MemWrite, MemtoReg},
//   and the default multiplier occupancy.
package pipe_pkg;

  // ALUOp classes driven by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores: address add
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branches: compare by subtract
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode further from funct
  localparam logic [1:0] ALUOP_IMM   = 2'b11;  // immediate logic ops

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  // Bit positions inside the control bundle
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  // Cycles HI/LO stay owned by the multiplier after a MULTU enters EX
  localparam int MULT_CYCLES_DEFAULT = 32;

  // True for any R-type instruction that reads or writes HI/LO
  function automatic logic uses_hilo(input logic [1:0] alu_op, input logic [5:0] funct);
    return (alu_op == ALUOP_RTYPE) &&
           ((funct == FUNCT_MULTU) || (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect -- purely combinational stall decision for the ID stage.
//   Inputs : the ID instruction (valid, ALUOp, Funct, rs, rt), the flush
//            request, what currently sits in EX (valid, MemRead, rd) and
//            the multiplier busy flag.
//   Outputs: stall_id plus the two individual hazard terms.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic       flush,
  input  logic [1:0] id_ALUOp,
  input  logic [5:0] id_Funct,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       mult_busy,
  output logic       load_use,
  output logic       hilo_hazard,
  output logic       stall_id
);

  always_comb begin
    // r0 is hard-wired zero, so a load targeting it never produces a value to wait on
    load_use    = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs) | (ex_rd == id_rt));
    hilo_hazard = mult_busy & uses_hilo(id_ALUOp, id_Funct);
    // A taken branch squashes the ID instruction, so holding it would be pointless
    stall_id    = id_valid & ~flush & (load_use | hilo_hazard);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with load-use and HI/LO stall logic.
//   Clock/reset : clk (rising edge), reset (asynchronous, active low).
//   ID inputs   : id_valid, id_ALUOp, id_Funct, id_shamt, id_rs_data,
//                 id_rt_data, id_imm, id_ALUSrc, id_rs, id_rt, id_rd, id_ctrl.
//   Control     : flush squashes the ID instruction.
//   EX outputs  : registered ALU operands, store data, destination, control, valid.
//   Status      : stall_id (combinational) freezes PC and IF/ID; mult_busy
//                 is high while the multiplier owns HI/LO.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [1:0]  id_ALUOp,
  input  logic [5:0]  id_Funct,
  input  logic [4:0]  id_shamt,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        id_ALUSrc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_ctrl,
  input  logic        flush,
  output logic [1:0]  ex_ALUOp,
  output logic [5:0]  ex_Funct,
  output logic [4:0]  ex_shamt,
  output logic [31:0] ex_dataA,
  output logic [31:0] ex_dataB,
  output logic [31:0] ex_rt_data,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_ctrl,
  output logic        ex_valid,
  output logic        stall_id,
  output logic        mult_busy
);

  localparam int CNT_W = $clog2(MULT_CYCLES + 1);

  logic [1:0]       alu_op_q,   alu_op_d;
  logic [5:0]       funct_q,    funct_d;
  logic [4:0]       shamt_q,    shamt_d;
  logic [31:0]      data_a_q,   data_a_d;
  logic [31:0]      data_b_q,   data_b_d;
  logic [31:0]      rt_data_q,  rt_data_d;
  logic [4:0]       rd_q,       rd_d;
  logic [3:0]       ctrl_q,     ctrl_d;
  logic             valid_q,    valid_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic load_bubble;
  logic load_use;
  logic hilo_hazard;

  hazard_detect u_hazard (
    .id_valid    (id_valid),
    .flush       (flush),
    .id_ALUOp    (id_ALUOp),
    .id_Funct    (id_Funct),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[CTRL_MEMREAD]),
    .ex_rd       (rd_q),
    .mult_busy   (mult_busy),
    .load_use    (load_use),
    .hilo_hazard (hilo_hazard),
    .stall_id    (stall_id)
  );

  assign mult_busy   = (cnt_q != '0);
  assign load_bubble = ~id_valid | flush | stall_id;

  always_comb begin
    // Bubble by default: every field zero so downstream sees a clean no-op
    alu_op_d  = '0;
    funct_d   = '0;
    shamt_d   = '0;
    data_a_d  = '0;
    data_b_d  = '0;
    rt_data_d = '0;
    rd_d      = '0;
    ctrl_d    = '0;
    valid_d   = 1'b0;
    if (!load_bubble) begin
      alu_op_d  = id_ALUOp;
      funct_d   = id_Funct;
      shamt_d   = id_shamt;
      data_a_d  = id_rs_data;
      data_b_d  = id_ALUSrc ? id_imm : id_rt_data;
      rt_data_d = id_rt_data;
      rd_d      = id_rd;
      ctrl_d    = id_ctrl;
      valid_d   = 1'b1;
    end

    // A MULTU actually entering EX restarts the occupancy count; flush does
    // not touch an in-flight count because the multiply has already issued.
    cnt_d = cnt_q;
    if (!load_bubble && (id_ALUOp == ALUOP_RTYPE) && (id_Funct == FUNCT_MULTU)) begin
      cnt_d = CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_op_q  <= '0;
      funct_q   <= '0;
      shamt_q   <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      rt_data_q <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      alu_op_q  <= alu_op_d;
      funct_q   <= funct_d;
      shamt_q   <= shamt_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      rt_data_q <= rt_data_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_ALUOp   = alu_op_q;
  assign ex_Funct   = funct_q;
  assign ex_shamt   = shamt_q;
  assign ex_dataA   = data_a_q;
  assign ex_dataB   = data_b_q;
  assign ex_rt_data = rt_data_q;
  assign ex_rd      = rd_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_valid   = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed, table-driven bench for id_ex_stage plus
// hand-written multiply and reset sequences.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_ALUOp;
  logic [5:0]  id_Funct;
  logic [4:0]  id_shamt;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic        id_ALUSrc;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [3:0]  id_ctrl;
  logic        flush;
  logic [1:0]  ex_ALUOp;
  logic [5:0]  ex_Funct;
  logic [4:0]  ex_shamt;
  logic [31:0] ex_dataA;
  logic [31:0] ex_dataB;
  logic [31:0] ex_rt_data;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_ctrl;
  logic        ex_valid;
  logic        stall_id;
  logic        mult_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  id_ex_stage #(.MULT_CYCLES(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_ALUOp   (id_ALUOp),
    .id_Funct   (id_Funct),
    .id_shamt   (id_shamt),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm     (id_imm),
    .id_ALUSrc  (id_ALUSrc),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_ctrl    (id_ctrl),
    .flush      (flush),
    .ex_ALUOp   (ex_ALUOp),
    .ex_Funct   (ex_Funct),
    .ex_shamt   (ex_shamt),
    .ex_dataA   (ex_dataA),
    .ex_dataB   (ex_dataB),
    .ex_rt_data (ex_rt_data),
    .ex_rd      (ex_rd),
    .ex_ctrl    (ex_ctrl),
    .ex_valid   (ex_valid),
    .stall_id   (stall_id),
    .mult_busy  (mult_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        alusrc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic        flush;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic v, input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
    input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] im, input logic src,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] ct,
    input logic fl, input logic es, input logic ev, input logic [31:0] ea, input logic [31:0] eb);
    vec_t r;
    r.valid = v;   r.aluop = op;   r.funct = fn;   r.shamt = sh;
    r.rs_data = rsd; r.rt_data = rtd; r.imm = im; r.alusrc = src;
    r.rs = rs; r.rt = rt; r.rd = rd; r.ctrl = ct; r.flush = fl;
    r.e_stall = es; r.e_valid = ev; r.e_a = ea; r.e_b = eb;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] ct,
                       input logic fl);
    id_valid   = v;
    id_ALUOp   = 2'b10;
    id_Funct   = fn;
    id_shamt   = 5'd0;
    id_rs_data = 32'd3;
    id_rt_data = 32'd4;
    id_imm     = 32'd0;
    id_ALUSrc  = 1'b0;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_ctrl    = ct;
    flush      = fl;
  endtask

  initial begin : main
    int  stalls;
    logic done;
    vec_t v;

    // {valid, aluop, funct, shamt, rs_data, rt_data, imm, alusrc, rs, rt, rd, ctrl, flush,
    //  exp stall, exp valid, exp dataA, exp dataB}
    vecs[0]  = mk(1, 2'b10, F_ADD, 0,   5,  7,  0, 0, 1, 2, 3,  4'b1000, 0, 0, 1,   5,  7); // ADD r3,r1,r2
    vecs[1]  = mk(1, 2'b00, 6'h0,  0, 100,  9, 16, 1, 1, 4, 4,  4'b1101, 0, 0, 1, 100, 16); // LW r4
    vecs[2]  = mk(1, 2'b10, F_ADD, 0,   1,  2,  0, 0, 6, 4, 5,  4'b1000, 0, 1, 0,   0,  0); // uses r4: stall
    vecs[3]  = mk(1, 2'b10, F_ADD, 0,   1,  2,  0, 0, 6, 4, 5,  4'b1000, 0, 0, 1,   1,  2); // re-presented
    vecs[4]  = mk(1, 2'b00, 6'h0,  0,   8,  0,  4, 1, 1, 0, 0,  4'b1101, 0, 0, 1,   8,  4); // LW r0
    vecs[5]  = mk(1, 2'b10, F_ADD, 0,   0,  3,  0, 0, 0, 3, 7,  4'b1000, 0, 0, 1,   0,  3); // uses r0: no stall
    vecs[6]  = mk(1, 2'b00, 6'h0,  0,  20,  0,  8, 1, 2, 9, 9,  4'b1101, 0, 0, 1,  20,  8); // LW r9
    vecs[7]  = mk(1, 2'b10, F_ADD, 0,  11, 12,  0, 0, 9, 1, 10, 4'b1000, 1, 0, 0,   0,  0); // hazard + flush
    vecs[8]  = mk(1, 2'b00, 6'h0,  0,  40, 32'h55, 12, 1, 1, 2, 0, 4'b0010, 0, 0, 1, 40, 12); // SW
    vecs[9]  = mk(0, 2'b10, F_ADD, 0,   1,  2,  3, 0, 1, 2, 3,  4'b1000, 0, 0, 0,   0,  0); // invalid
    vecs[10] = mk(1, 2'b10, F_SLL, 5,   0, 32'h0F, 0, 0, 0, 2, 3, 4'b1000, 0, 0, 1, 0, 32'h0F); // SLL
    vecs[11] = mk(1, 2'b00, 6'h0,  0,  64,  0,  0, 1, 1, 6, 6,  4'b1101, 0, 0, 1,  64,  0); // LW r6
    vecs[12] = mk(1, 2'b10, F_SUB, 0,  30,  4,  0, 0, 6, 1, 8,  4'b1000, 0, 1, 0,   0,  0); // uses r6 as rs
    vecs[13] = mk(1, 2'b10, F_SUB, 0,  30,  4,  0, 0, 6, 1, 8,  4'b1000, 0, 0, 1,  30,  4);
    vecs[14] = mk(1, 2'b00, 6'h0,  0,   1,  0,  0, 1, 1, 2, 2,  4'b1101, 0, 0, 1,   1,  0); // LW r2
    vecs[15] = mk(0, 2'b10, F_ADD, 0,   5,  5,  0, 0, 2, 2, 4,  4'b1000, 0, 0, 0,   0,  0); // invalid, rs=r2

    // ---- reset: asynchronous clear before any clock edge ----
    drive(1'b0, F_ADD, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset_ex", {ex_valid, ex_ctrl, ex_ALUOp, ex_Funct, ex_shamt, ex_rd}, '0);
    check("reset_data", {ex_dataA, ex_dataB, ex_rt_data}, '0);
    check("reset_status", {stall_id, mult_busy}, '0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;

    // ---- table-driven single-cycle vectors ----
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      id_valid = v.valid; id_ALUOp = v.aluop; id_Funct = v.funct; id_shamt = v.shamt;
      id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm; id_ALUSrc = v.alusrc;
      id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_ctrl = v.ctrl; flush = v.flush;
      @(negedge clk);
      check($sformatf("v%0d_stall", i), 128'(stall_id), 128'(v.e_stall));
      tick();
      check($sformatf("v%0d_ops", i), {ex_valid, ex_dataA, ex_dataB}, {v.e_valid, v.e_a, v.e_b});
      check($sformatf("v%0d_fields", i),
            {ex_ctrl, ex_ALUOp, ex_Funct, ex_shamt, ex_rd, ex_rt_data},
            v.e_valid ? {v.ctrl, v.aluop, v.funct, v.shamt, v.rd, v.rt_data} : 128'd0);
      $display("vec %0d: stall=%0b ex_valid=%0b A=%0h B=%0h rd=%0d", i, v.e_stall, ex_valid,
               ex_dataA, ex_dataB, ex_rd);
    end

    // ---- MULTU then MFLO: exactly 32 stall cycles ----
    drive(1'b1, F_MULTU, 5'd1, 5'd2, 5'd0, 4'b0000, 1'b0);
    @(negedge clk);
    check("multu_stall", 128'(stall_id), 128'd0);
    tick();
    check("multu_ex", {ex_valid, ex_Funct, mult_busy}, {1'b1, F_MULTU, 1'b1});
    drive(1'b1, F_MFLO, 5'd0, 5'd0, 5'd8, 4'b1000, 1'b0);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall_id) stalls++;
      else begin
        done = 1'b1;
        check("mflo_busy_clear", 128'(mult_busy), 128'd0);
      end
      tick();
      if (!done) check("mflo_bubble", 128'(ex_valid), 128'd0);
    end
    check("mflo_done", 128'(done), 128'd1);
    check("mflo_stall_cycles", 128'(stalls), 128'd32);
    check("mflo_ex", {ex_valid, ex_Funct, ex_rd}, {1'b1, F_MFLO, 5'd8});
    $display("mult: MFLO stalled %0d cycles", stalls);

    // ---- MULTU, then ADDs proceed while busy, then MFHI stalls, flush overrides ----
    drive(1'b1, F_MULTU, 5'd1, 5'd2, 5'd0, 4'b0000, 1'b0);
    tick();                                                   // cnt = 32
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, F_ADD, 5'd1, 5'd2, 5'(10 + k), 4'b1000, 1'b0);
      @(negedge clk);
      check($sformatf("busy_add%0d_stall", k), {stall_id, mult_busy}, {1'b0, 1'b1});
      tick();                                                 // cnt = 31, 30, 29
      check($sformatf("busy_add%0d_ex", k), {ex_valid, ex_rd}, {1'b1, 5'(10 + k)});
    end
    drive(1'b1, F_MFHI, 5'd0, 5'd0, 5'd9, 4'b1000, 1'b0);
    @(negedge clk);
    check("mfhi_busy_stall", 128'(stall_id), 128'd1);
    flush = 1'b1;
    #1;
    check("mfhi_flush_stall", 128'(stall_id), 128'd0);
    tick();                                                   // cnt = 28
    check("mfhi_flush_ex", {ex_valid, ex_ctrl, ex_Funct}, '0);
    check("flush_keeps_cnt", 128'(mult_busy), 128'd1);
    $display("mult: ADDs passed while busy, flushed MFHI bubbled");

    // ---- reset mid-multiply at cnt = 10 ----
    drive(1'b0, F_ADD, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0);
    for (int k = 0; k < 18; k++) tick();                      // cnt = 10
    check("pre_reset_busy", 128'(mult_busy), 128'd1);
    drive(1'b1, F_MFHI, 5'd0, 5'd0, 5'd9, 4'b1000, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midreset_clear", {ex_valid, mult_busy, stall_id}, '0);
    tick();
    check("midreset_hold", {ex_valid, mult_busy, stall_id, ex_Funct}, '0);
    #2 reset = 1'b1;
    @(negedge clk);
    check("post_reset_stall", {stall_id, mult_busy}, '0);
    tick();
    check("post_reset_mfhi", {ex_valid, ex_Funct, ex_rd}, {1'b1, F_MFHI, 5'd9});
    $display("reset: mid-multiply abort, MFHI entered EX");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter MULT_CYCLES, default 32, number of cycles the multiplier occupies HI/LO after a MULTU enters EX.
REQ-002 clk  in  1  rising-edge clock; the block's single clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 id_valid  in  1  ID holds a real instruction.
REQ-005 id_ALUOp  in  2  ALU operation class from main decoder.
REQ-006 id_Funct  in  6  R-type funct field.
REQ-007 id_shamt  in  5  shift amount field.
REQ-008 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-009 id_imm  in  32  sign-extended immediate.
REQ-010 id_ALUSrc  in  1  1 selects id_imm as operand B.
REQ-011 id_rs, id_rt, id_rd  in  5 each  source and resolved destination register numbers.
REQ-012 id_ctrl  in  4  {RegWrite, MemRead, MemWrite, MemtoReg}.
REQ-013 flush  in  1  branch taken; squash the ID instruction.
REQ-014 ex_ALUOp 2, ex_Funct 6, ex_shamt 5, ex_dataA 32, ex_dataB 32  out  registered operands for the EX ALU block.
REQ-015 ex_rt_data 32, ex_rd 5, ex_ctrl 4, ex_valid 1  out  registered store data, destination, control, valid.
REQ-016 stall_id  out  1  freeze PC and IF/ID this cycle.
REQ-017 mult_busy  out  1  multiply in progress.

Function
REQ-018 Without stall/flush, all ex_* outputs SHALL capture ID values at the next rising edge (latency 1); ex_dataB = id_ALUSrc ? id_imm : id_rt_data; ex_dataA = id_rs_data.
REQ-019 Bubble: ex_valid=0, ex_ctrl=0, ex_ALUOp=0, ex_Funct=0; other ex_* fields don't-care but SHALL be zeroed.
REQ-020 Load-use hazard = ex_valid & ex_ctrl.MemRead & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
REQ-021 HI/LO hazard = mult_busy & id_ALUOp==2'b10 & id_Funct in {MULTU 011001, MFHI 010000, MFLO 010010}.
REQ-022 stall_id SHALL be combinational = id_valid & ~flush & (load-use | HI/LO hazard).
REQ-023 On stall_id=1 the EX register SHALL load a bubble; the ID instruction is re-presented next cycle.
REQ-024 flush=1 SHALL load a bubble and force stall_id=0 (flush beats stall).
REQ-025 id_valid=0 SHALL load a bubble.
REQ-026 Counter cnt (width clog2(MULT_CYCLES+1)): loads MULT_CYCLES on the edge a valid MULTU is captured into EX; otherwise decrements when nonzero, holds at 0.
REQ-027 mult_busy = (cnt != 0); flush SHALL NOT clear cnt (an issued MULTU completes).
REQ-028 MFHI in ID the cycle after MULTU enters EX SHALL stall exactly MULT_CYCLES cycles, then enter EX.
REQ-029 Non-HI/LO instructions SHALL proceed normally while mult_busy=1.
REQ-030 Register 0 as destination SHALL never create a load-use stall.

Reset
REQ-031 reset low SHALL immediately clear every ex_* output and cnt to 0 (bubble, mult_busy=0), independent of clk.
REQ-032 stall_id SHALL read 0 while reset is low; first capture occurs on the first rising edge after reset deasserts.
REQ-033 Reset asserted mid-multiply SHALL abort the count; no residual stall after release.

Structure
REQ-034 Shared package pipe_pkg SHALL hold ALUOp codes, Funct constants (ADD, SUB, AND, OR, SLT, SLL, MULTU, MFHI, MFLO), id_ctrl bit indices, MULT_CYCLES default.
REQ-035 Hazard logic (REQ-020..022) SHALL be a combinational sub-module hazard_detect; register and counter live in id_ex_stage.

Verification
REQ-036 ADD r3,r1,r2 with id_rs_data=5, id_rt_data=7, ALUSrc=0 -> next cycle ex_dataA=5, ex_dataB=7, ex_valid=1, stall_id=0.
REQ-037 LW r4 in EX (MemRead=1, ex_rd=4), ID ADD using rt=4 -> stall_id=1 one cycle, bubble in EX, ADD enters EX following cycle.
REQ-038 MULTU enters EX, MFLO in ID next cycle -> stall_id=1 for 32 cycles, mult_busy falls, MFLO in EX on cycle 33; ADD in its place never stalls.
REQ-039 Load-use hazard with flush=1 same cycle -> stall_id=0, bubble in EX.
REQ-040 reset low at cnt=10 -> ex_valid=0, mult_busy=0 immediately; after release MFHI proceeds with no stall.
REQ-041 LW with ex_rd=0, ID uses rs=0 -> no stall.
